// File: rtl/rv32i_inst_encoder.sv
// rv32i_inst_encoder: streaming RV32I encoder, mnemonic+fields -> word+addr.
// Ports: clk, rst_n, clr, in_* (valid/ready bundle), out_* (word, addr,
// illegal flag, valid/ready). Option: INST_ENC_RANGE_CHECK_EN.
module rv32i_inst_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_mnem,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_addr,
  output logic        out_illegal
);

  typedef enum logic [2:0] {
    F_I, F_SH, F_S, F_R, F_U, F_B, F_J, F_X
  } fmt_e;

  typedef struct packed {
    fmt_e       fmt;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
  } ctl_t;

  logic        s1_valid_q, s1_valid_d;
  logic [5:0]  s1_mnem_q, s1_mnem_d;
  logic [4:0]  s1_rd_q, s1_rd_d;
  logic [4:0]  s1_rs1_q, s1_rs1_d;
  logic [4:0]  s1_rs2_q, s1_rs2_d;
  logic [31:0] s1_imm_q, s1_imm_d;
  logic        s2_valid_q, s2_valid_d;
  logic [31:0] s2_inst_q, s2_inst_d;
  logic        s2_ill_q, s2_ill_d;
  logic [31:0] addr_q, addr_d;

  ctl_t        ctl;
  logic [31:0] enc_inst;
  logic        enc_ill;
  logic        rng_bad;
  logic        s1_move;

  always_comb begin
    ctl = '{F_X, 7'h13, 3'd0, 7'h00};
    unique case (s1_mnem_q)
      6'd0:  ctl = '{F_I,  7'h03, 3'd0, 7'h00};
      6'd1:  ctl = '{F_I,  7'h03, 3'd1, 7'h00};
      6'd2:  ctl = '{F_I,  7'h03, 3'd2, 7'h00};
      6'd3:  ctl = '{F_I,  7'h03, 3'd4, 7'h00};
      6'd4:  ctl = '{F_I,  7'h03, 3'd5, 7'h00};
      6'd5:  ctl = '{F_I,  7'h13, 3'd0, 7'h00};
      6'd6:  ctl = '{F_SH, 7'h13, 3'd1, 7'h00};
      6'd7:  ctl = '{F_I,  7'h13, 3'd2, 7'h00};
      6'd8:  ctl = '{F_I,  7'h13, 3'd3, 7'h00};
      6'd9:  ctl = '{F_I,  7'h13, 3'd4, 7'h00};
      6'd10: ctl = '{F_SH, 7'h13, 3'd5, 7'h00};
      6'd11: ctl = '{F_SH, 7'h13, 3'd5, 7'h20};
      6'd12: ctl = '{F_I,  7'h13, 3'd6, 7'h00};
      6'd13: ctl = '{F_I,  7'h13, 3'd7, 7'h00};
      6'd14: ctl = '{F_U,  7'h17, 3'd0, 7'h00};
      6'd15: ctl = '{F_S,  7'h23, 3'd0, 7'h00};
      6'd16: ctl = '{F_S,  7'h23, 3'd1, 7'h00};
      6'd17: ctl = '{F_S,  7'h23, 3'd2, 7'h00};
      6'd18: ctl = '{F_R,  7'h33, 3'd0, 7'h00};
      6'd19: ctl = '{F_R,  7'h33, 3'd0, 7'h20};
      6'd20: ctl = '{F_R,  7'h33, 3'd1, 7'h00};
      6'd21: ctl = '{F_R,  7'h33, 3'd2, 7'h00};
      6'd22: ctl = '{F_R,  7'h33, 3'd3, 7'h00};
      6'd23: ctl = '{F_R,  7'h33, 3'd4, 7'h00};
      6'd24: ctl = '{F_R,  7'h33, 3'd5, 7'h00};
      6'd25: ctl = '{F_R,  7'h33, 3'd5, 7'h20};
      6'd26: ctl = '{F_R,  7'h33, 3'd6, 7'h00};
      6'd27: ctl = '{F_R,  7'h33, 3'd7, 7'h00};
      6'd28: ctl = '{F_U,  7'h37, 3'd0, 7'h00};
      6'd29: ctl = '{F_B,  7'h63, 3'd0, 7'h00};
      6'd30: ctl = '{F_B,  7'h63, 3'd1, 7'h00};
      6'd31: ctl = '{F_B,  7'h63, 3'd4, 7'h00};
      6'd32: ctl = '{F_B,  7'h63, 3'd5, 7'h00};
      6'd33: ctl = '{F_B,  7'h63, 3'd6, 7'h00};
      6'd34: ctl = '{F_B,  7'h63, 3'd7, 7'h00};
      6'd35: ctl = '{F_I,  7'h67, 3'd0, 7'h00};
      6'd36: ctl = '{F_J,  7'h6f, 3'd0, 7'h00};
      default: ;
    endcase
  end

`ifdef INST_ENC_RANGE_CHECK_EN
  logic i_ok, b_ok, j_ok;
  assign i_ok = (&s1_imm_q[31:11]) | ~(|s1_imm_q[31:11]);
  assign b_ok = ((&s1_imm_q[31:12]) | ~(|s1_imm_q[31:12]))
              & ~s1_imm_q[0];
  assign j_ok = ((&s1_imm_q[31:20]) | ~(|s1_imm_q[31:20]))
              & ~s1_imm_q[0];
  always_comb begin
    rng_bad = 1'b0;
    unique case (ctl.fmt)
      F_I, F_S: rng_bad = ~i_ok;
      F_SH:     rng_bad = |s1_imm_q[31:5];
      F_U:      rng_bad = |s1_imm_q[31:20];
      F_B:      rng_bad = ~b_ok;
      F_J:      rng_bad = ~j_ok;
      default:  rng_bad = 1'b0;
    endcase
  end
`else
  logic unused_imm;
  assign unused_imm = ^s1_imm_q[31:21];
  assign rng_bad = 1'b0;
`endif

  always_comb begin
    enc_inst = 32'h0000_0013;
    enc_ill  = rng_bad;
    unique case (ctl.fmt)
      F_I: enc_inst = {s1_imm_q[11:0], s1_rs1_q, ctl.f3,
                       s1_rd_q, ctl.op};
      F_SH: enc_inst = {ctl.f7, s1_imm_q[4:0], s1_rs1_q,
                        ctl.f3, s1_rd_q, ctl.op};
      F_S: enc_inst = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q,
                       ctl.f3, s1_imm_q[4:0], ctl.op};
      F_R: enc_inst = {ctl.f7, s1_rs2_q, s1_rs1_q, ctl.f3,
                       s1_rd_q, ctl.op};
      F_U: enc_inst = {s1_imm_q[19:0], s1_rd_q, ctl.op};
      F_B: enc_inst = {s1_imm_q[12], s1_imm_q[10:5],
                       s1_rs2_q, s1_rs1_q, ctl.f3,
                       s1_imm_q[4:1], s1_imm_q[11], ctl.op};
      F_J: enc_inst = {s1_imm_q[20], s1_imm_q[10:1],
                       s1_imm_q[11], s1_imm_q[19:12],
                       s1_rd_q, ctl.op};
      default: enc_ill = 1'b1;
    endcase
  end

  assign s1_move     = ~s2_valid_q | out_ready;
  assign in_ready    = ~s1_valid_q | s1_move;
  assign out_valid   = s2_valid_q;
  assign out_inst    = s2_inst_q;
  assign out_illegal = s2_ill_q;
  assign out_addr    = addr_q;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_mnem_d  = s1_mnem_q;
    s1_rd_d    = s1_rd_q;
    s1_rs1_d   = s1_rs1_q;
    s1_rs2_d   = s1_rs2_q;
    s1_imm_d   = s1_imm_q;
    s2_valid_d = s2_valid_q;
    s2_inst_d  = s2_inst_q;
    s2_ill_d   = s2_ill_q;
    addr_d     = addr_q;
    if (clr) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
      addr_d     = BASE_ADDR;
    end else begin
      if (s2_valid_q & out_ready) addr_d = addr_q + 32'd4;
      if (s1_move) begin
        s2_valid_d = s1_valid_q;
        if (s1_valid_q) begin
          s2_inst_d = enc_inst;
          s2_ill_d  = enc_ill;
        end
      end
      // s1 is always empty or draining when in_ready is high
      if (in_ready) begin
        s1_valid_d = in_valid;
        if (in_valid) begin
          s1_mnem_d = in_mnem;
          s1_rd_d   = in_rd;
          s1_rs1_d  = in_rs1;
          s1_rs2_d  = in_rs2;
          s1_imm_d  = in_imm;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_mnem_q  <= '0;
      s1_rd_q    <= '0;
      s1_rs1_q   <= '0;
      s1_rs2_q   <= '0;
      s1_imm_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_inst_q  <= '0;
      s2_ill_q   <= 1'b0;
      addr_q     <= BASE_ADDR;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_mnem_q  <= s1_mnem_d;
      s1_rd_q    <= s1_rd_d;
      s1_rs1_q   <= s1_rs1_d;
      s1_rs2_q   <= s1_rs2_d;
      s1_imm_q   <= s1_imm_d;
      s2_valid_q <= s2_valid_d;
      s2_inst_q  <= s2_inst_d;
      s2_ill_q   <= s2_ill_d;
      addr_q     <= addr_d;
    end
  end

endmodule

// File: tb/tb_rv32i_inst_encoder.sv
// tb_rv32i_inst_encoder: directed vectors against a field-level
// RV32I encoding model with a per-cycle scoreboard.
module tb_rv32i_inst_encoder;

  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam logic [31:0] BASE2 = 32'hFFFF_FFF8;
`ifdef INST_ENC_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  localparam logic [6:0] OPT [37] = '{
    7'h03, 7'h03, 7'h03, 7'h03, 7'h03,
    7'h13, 7'h13, 7'h13, 7'h13, 7'h13, 7'h13, 7'h13, 7'h13, 7'h13,
    7'h17, 7'h23, 7'h23, 7'h23,
    7'h33, 7'h33, 7'h33, 7'h33, 7'h33, 7'h33, 7'h33, 7'h33, 7'h33, 7'h33,
    7'h37, 7'h63, 7'h63, 7'h63, 7'h63, 7'h63, 7'h63, 7'h67, 7'h6f};
  localparam logic [2:0] F3T [37] = '{
    3'd0, 3'd1, 3'd2, 3'd4, 3'd5,
    3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd6, 3'd7,
    3'd0, 3'd0, 3'd1, 3'd2,
    3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd6, 3'd7,
    3'd0, 3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd0};
  localparam byte FMT [37] = '{
    "I", "I", "I", "I", "I",
    "I", "H", "I", "I", "I", "H", "H", "I", "I",
    "U", "S", "S", "S",
    "R", "R", "R", "R", "R", "R", "R", "R", "R", "R",
    "U", "B", "B", "B", "B", "B", "B", "I", "J"};

  typedef struct {
    logic [31:0] inst;
    logic        ill;
    int          cyc;
  } exp_t;
  typedef struct {
    logic [31:0] inst;
    logic        ill;
    logic [31:0] addr;
  } rec_t;

  logic        clk, rst_n, clr, in_valid, out_ready;
  logic [5:0]  in_mnem;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm;
  logic        in_ready, out_valid, out_illegal;
  logic [31:0] out_inst, out_addr;
  logic        in_ready2, out_valid2, out_illegal2;
  logic [31:0] out_inst2, out_addr2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit lat_chk = 0;
  bit saw_stall = 0;
  exp_t q[$];
  rec_t log1[$];
  logic [31:0] log2[$];
  logic [31:0] exp_addr, exp_addr2;
  bit held = 0;
  rec_t hv;

  rv32i_inst_encoder #(.BASE_ADDR(BASE)) u_dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mnem(in_mnem), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_addr(out_addr),
    .out_illegal(out_illegal));

  rv32i_inst_encoder #(.BASE_ADDR(BASE2)) u_wrap (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready2),
    .in_mnem(in_mnem), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid2), .out_ready(out_ready),
    .out_inst(out_inst2), .out_addr(out_addr2),
    .out_illegal(out_illegal2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Field-level encoding straight from the ISA layout tables.
  function automatic logic [32:0] model(
      input logic [5:0] m, input logic [4:0] rd5,
      input logic [4:0] rs15, input logic [4:0] rs25,
      input logic [31:0] imm);
    logic [31:0] op, f3, f7, rd, r1, r2, w;
    bit bad;
    int si;
    byte fmt;
    if (m > 6'd36) return {1'b1, 32'h0000_0013};
    op = 32'(OPT[int'(m)]);
    f3 = 32'(F3T[int'(m)]);
    fmt = FMT[int'(m)];
    f7 = (m == 11 || m == 19 || m == 25) ? 32'h20 : 32'h0;
    rd = 32'(rd5); r1 = 32'(rs15); r2 = 32'(rs25);
    si = $signed(imm);
    w = 0; bad = 0;
    case (fmt)
      "I": begin
        w = ((imm & 32'hfff) << 20) | (r1 << 15) | (f3 << 12)
          | (rd << 7) | op;
        bad = si < -2048 || si > 2047;
      end
      "H": begin
        w = (f7 << 25) | ((imm & 32'd31) << 20) | (r1 << 15)
          | (f3 << 12) | (rd << 7) | op;
        bad = imm > 32'd31;
      end
      "S": begin
        w = (((imm >> 5) & 32'd127) << 25) | (r2 << 20)
          | (r1 << 15) | (f3 << 12) | ((imm & 32'd31) << 7) | op;
        bad = si < -2048 || si > 2047;
      end
      "R": w = (f7 << 25) | (r2 << 20) | (r1 << 15) | (f3 << 12)
             | (rd << 7) | op;
      "U": begin
        w = ((imm & 32'hfffff) << 12) | (rd << 7) | op;
        bad = imm > 32'hfffff;
      end
      "B": begin
        w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 63) << 25)
          | (r2 << 20) | (r1 << 15) | (f3 << 12)
          | (((imm >> 1) & 15) << 8) | (((imm >> 11) & 1) << 7) | op;
        bad = si < -4096 || si > 4095 || imm[0];
      end
      default: begin
        w = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 1023) << 21)
          | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 255) << 12)
          | (rd << 7) | op;
        bad = si < -1048576 || si > 1048575 || imm[0];
      end
    endcase
    return {bad & RC, w};
  endfunction

  always @(negedge clk) begin
    logic [32:0] mv;
    exp_t e;
    rec_t r;
    cyc++;
    if (!rst_n || clr) begin
      q.delete();
      exp_addr = BASE;
      exp_addr2 = BASE2;
      held = 0;
    end else begin
      if (held) begin
        chk("stall_valid", out_valid, 1'b1);
        chk("stall_inst", out_inst, hv.inst);
        chk("stall_ill", out_illegal, hv.ill);
        chk("stall_addr", out_addr, hv.addr);
      end
      if (out_valid && out_ready) begin
        r = '{out_inst, out_illegal, out_addr};
        log1.push_back(r);
        if (q.size() == 0) begin
          chk("spurious_word", out_valid, 1'b0);
        end else begin
          e = q.pop_front();
          chk("inst", out_inst, e.inst);
          chk("illegal", out_illegal, e.ill);
          chk("addr", out_addr, exp_addr);
          if (lat_chk) chk("latency", cyc - e.cyc, 2);
        end
        exp_addr += 4;
      end
      if (out_valid2 && out_ready) begin
        log2.push_back(out_addr2);
        chk("wrap_addr", out_addr2, exp_addr2);
        exp_addr2 += 4;
      end
      held = out_valid && !out_ready;
      hv = '{out_inst, out_illegal, out_addr};
      if (in_valid && in_ready) begin
        mv = model(in_mnem, in_rd, in_rs1, in_rs2, in_imm);
        q.push_back('{mv[31:0], mv[32], cyc});
      end
      if (in_valid && !in_ready) saw_stall = 1;
    end
  end

  task automatic send(input logic [5:0] m, input logic [4:0] d,
                      input logic [4:0] a, input logic [4:0] b,
                      input logic [31:0] im);
    int n = 0;
    in_valid = 1; in_mnem = m; in_rd = d;
    in_rs1 = a; in_rs2 = b; in_imm = im;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) chk("send_timeout", n, 0);
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk);
    while ((q.size() != 0 || out_valid) && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("drain", q.size(), 0);
    @(posedge clk); #1;
  endtask

  logic [5:0]  vm [8] = '{6'd5, 6'd11, 6'd17, 6'd19,
                          6'd29, 6'd36, 6'd28, 6'd14};
  logic [4:0]  vd [8] = '{5'd1, 5'd13, 5'd0, 5'd4,
                          5'd0, 5'd1, 5'd1, 5'd1};
  logic [4:0]  va [8] = '{5'd2, 5'd14, 5'd1, 5'd5,
                          5'd1, 5'd0, 5'd0, 5'd0};
  logic [4:0]  vb [8] = '{5'd0, 5'd0, 5'd12, 5'd6,
                          5'd2, 5'd0, 5'd0, 5'd0};
  logic [31:0] vi [8] = '{32'd16, 32'd16, 32'd16, 32'd0,
                          32'd32, 32'd256, 32'hfffff, 32'd16};
  logic [31:0] vw [8] = '{32'h01010093, 32'h41075693,
                          32'h00c0a823, 32'h40628233,
                          32'h02208063, 32'h100000ef,
                          32'hfffff0b7, 32'h00010097};

  initial begin
    logic [32:0] mv;
    rst_n = 1; clr = 0; in_valid = 0; out_ready = 1;
    in_mnem = 0; in_rd = 0; in_rs1 = 0; in_rs2 = 0; in_imm = 0;
    #1 rst_n = 0;
    #2;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_inst", out_inst, 32'h0);
    chk("rst_ill", out_illegal, 1'b0);
    chk("rst_addr", out_addr, BASE);
    chk("rst_in_ready", in_ready, 1'b1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    for (int i = 0; i < 8; i++) begin
      mv = model(vm[i], vd[i], va[i], vb[i], vi[i]);
      chk("model_pin", mv[31:0], vw[i]);
    end

    lat_chk = 1;
    log1.delete();
    for (int i = 0; i < 8; i++) send(vm[i], vd[i], va[i], vb[i], vi[i]);
    drain();
    lat_chk = 0;
    chk("dir_count", log1.size(), 8);
    for (int i = 0; i < 8 && i < log1.size(); i++) begin
      chk("dir_word", log1[i].inst, vw[i]);
      chk("dir_addr", log1[i].addr, BASE + 32'(4 * i));
    end

    log1.delete();
    saw_stall = 0;
    fork
      for (int i = 0; i < 8; i++)
        send(6'(18 + i), 5'(i + 1), 5'(i + 2), 5'(i + 3), 32'h0);
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 0;
        repeat (4) @(posedge clk);
        #1 out_ready = 1;
      end
    join
    drain();
    chk("bp_count", log1.size(), 8);
    chk("bp_in_ready_low", saw_stall, 1'b1);
    for (int i = 1; i < 8 && i < log1.size(); i++)
      chk("bp_addr_step", log1[i].addr - log1[i-1].addr, 32'd4);

    log1.delete();
    send(6'd5, 5'd3, 5'd4, 5'd0, 32'd7);
    send(6'd40, 5'd3, 5'd4, 5'd5, 32'd7);
    drain();
    if (log1.size() == 2) begin
      chk("bad_mnem_inst", log1[1].inst, 32'h0000_0013);
      chk("bad_mnem_ill", log1[1].ill, 1'b1);
      chk("bad_mnem_step", log1[1].addr - log1[0].addr, 32'd4);
    end else chk("bad_mnem_count", log1.size(), 2);

    send(6'd18, 5'd1, 5'd2, 5'd3, 32'h0);
    send(6'd19, 5'd1, 5'd2, 5'd3, 32'h0);
    clr = 1; in_valid = 1; in_mnem = 6'd45;
    @(posedge clk); #1;
    clr = 0; in_valid = 0;
    chk("clr_flush", out_valid, 1'b0);
    log1.delete();
    send(6'd5, 5'd9, 5'd9, 5'd0, 32'd1);
    drain();
    chk("clr_count", log1.size(), 1);
    if (log1.size() > 0) chk("clr_addr", log1[0].addr, BASE);

    clr = 1;
    @(posedge clk); #1;
    clr = 0;
    log2.delete();
    for (int i = 0; i < 3; i++) send(6'd18, 5'(i), 5'd1, 5'd2, 32'h0);
    drain();
    chk("wrap_count", log2.size(), 3);
    if (log2.size() == 3) begin
      chk("wrap0", log2[0], 32'hFFFF_FFF8);
      chk("wrap1", log2[1], 32'hFFFF_FFFC);
      chk("wrap2", log2[2], 32'h0000_0000);
    end

    log1.delete();
    send(6'd5, 5'd1, 5'd0, 5'd0, 32'd2048);
    send(6'd29, 5'd0, 5'd1, 5'd2, 32'd3);
    drain();
    if (log1.size() == 2) begin
      chk("rc_addi_ill", log1[0].ill, RC);
      chk("rc_addi_imm", 32'(log1[0].inst[31:20]), 32'h800);
      chk("rc_beq_ill", log1[1].ill, RC);
    end else chk("rc_count", log1.size(), 2);

    send(6'd18, 5'd1, 5'd2, 5'd3, 32'h0);
    send(6'd19, 5'd1, 5'd2, 5'd3, 32'h0);
    rst_n = 0;
    #2;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_inst", out_inst, 32'h0);
    chk("mid_rst_addr", out_addr, BASE);
    chk("mid_rst_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    rst_n = 1;
    log1.delete();
    send(6'd13, 5'd2, 5'd3, 5'd0, 32'hff);
    drain();
    chk("post_rst_count", log1.size(), 1);
    if (log1.size() > 0) chk("post_rst_addr", log1[0].addr, BASE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
